seg_scan_multi: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment scanner. It replaces the fixed
//  2-digit mode/op and countdown scanners with one generic engine.
//  A producer (FSM or a display formatter) loads a frame of per-digit glyph

---
 rtl/seg_scan_multi.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_multi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_multi.sv
// seg_scan_multi: N-digit multiplexed 7-segment scanner, double-buffered frames.
// Frames commit at frame end; per-slot blanking, blink and output polarity.
//  clk, rst_n          : clock, async active-low reset
//  upd_valid/upd_ready : frame offer / shadow buffer free
//  upd_codes/dp/blink  : per-digit glyph code (5b), decimal point, blink enable
//  seg (GFEDCBA), dp   : segment outputs, polarity per SEG_ACTIVE_HIGH
//  dig_sel             : digit enables, polarity per SEL_ACTIVE_HIGH
//  frame_tick          : 1-cycle pulse after each frame end
module seg_scan_multi #(
  parameter int NUM_DIGITS      = 8,
  parameter int SCAN_DIV        = 100000,
  parameter int BLANK_CYC       = 1000,
  parameter int BLINK_FRAMES    = 64,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int SEL_ACTIVE_HIGH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [5*NUM_DIGITS-1:0] upd_codes,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blink,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_HIGH == 0);
  localparam logic SEL_INV = (SEL_ACTIVE_HIGH == 0);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [5*NUM_DIGITS-1:0] BLANK_CODES = {NUM_DIGITS{5'd31}};

  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] dig_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          pending;

  logic [5*NUM_DIGITS-1:0] act_codes, sh_codes;
  logic [NUM_DIGITS-1:0]   act_dp, sh_dp;
  logic [NUM_DIGITS-1:0]   act_blink, sh_blink;

  logic                  frame_end;
  logic [0:0]            phase;
  logic [4:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blink;
  logic [NUM_DIGITS-1:0] sel_hot;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] sel_on;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 7'b0111111;
      5'd1:    glyph = 7'b0000110;
      5'd2:    glyph = 7'b1011011;
      5'd3:    glyph = 7'b1001111;
      5'd4:    glyph = 7'b1100110;
      5'd5:    glyph = 7'b1101101;
      5'd6:    glyph = 7'b1111101;
      5'd7:    glyph = 7'b0000111;
      5'd8:    glyph = 7'b1111111;
      5'd9:    glyph = 7'b1101111;
      5'd10:   glyph = 7'b1110111;
      5'd11:   glyph = 7'b1111100;
      5'd12:   glyph = 7'b0111001;
      5'd13:   glyph = 7'b1011110;
      5'd14:   glyph = 7'b1111001;
      5'd15:   glyph = 7'b1110001;
      5'd16:   glyph = 7'b1111000;
      5'd17:   glyph = 7'b0001110;
      5'd18:   glyph = 7'b1000000;
      5'd19:   glyph = 7'b1110011;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  assign upd_ready = ~pending;
  assign frame_end = (slot_cnt == SLOT_LAST)
                   && (dig_idx == DIG_LAST);

  always_comb begin
    phase = (slot_cnt < BLANK_LIM) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    cur_code  = 5'd31;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == DW'(i)) begin
        cur_code   = act_codes[5*i +: 5];
        cur_dp     = act_dp[i];
        cur_blink  = act_blink[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  // Blinked digits keep their select pulse so scan timing stays uniform.
  always_comb begin
    seg_on = '0;
    dp_on  = 1'b0;
    sel_on = '0;
    if (phase == ST_SHOW) begin
      sel_on = sel_hot;
      if (!(cur_blink && blink_phase)) begin
        seg_on = glyph(cur_code);
        dp_on  = cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_LAST) ? '0
                : dig_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Capture needs pending=0 and commit needs pending=1, so
  // a capture on the frame-end cycle waits for the next frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b0;
      frame_tick  <= 1'b0;
      act_codes   <= BLANK_CODES;
      act_dp      <= '0;
      act_blink   <= '0;
      sh_codes    <= BLANK_CODES;
      sh_dp       <= '0;
      sh_blink    <= '0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (pending) begin
          act_codes <= sh_codes;
          act_dp    <= sh_dp;
          act_blink <= sh_blink;
          pending   <= 1'b0;
        end
      end
      if (upd_valid && !pending) begin
        sh_codes <= upd_codes;
        sh_dp    <= upd_dp;
        sh_blink <= upd_blink;
        pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= {7{SEG_INV}};
      dp      <= SEG_INV;
      dig_sel <= {NUM_DIGITS{SEL_INV}};
    end else begin
      seg     <= seg_on ^ {7{SEG_INV}};
      dp      <= dp_on ^ SEG_INV;
      dig_sel <= sel_on ^ {NUM_DIGITS{SEL_INV}};
    end
  end

endmodule

// File: tb/tb_seg_scan_multi.sv
// tb_seg_scan_multi: scoreboard bench for seg_scan_multi.
// Active-high and active-low instances share stimulus.
module tb_seg_scan_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        upd_valid;
  logic [19:0] upd_codes;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blink;

  logic       ready_a, ready_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] sel_a, sel_b;
  logic       tick_a, tick_b;

  seg_scan_multi #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
    .BLINK_FRAMES(2), .SEG_ACTIVE_HIGH(1),
    .SEL_ACTIVE_HIGH(1)
  ) u_hi (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(ready_a),
    .upd_codes(upd_codes), .upd_dp(upd_dp),
    .upd_blink(upd_blink), .seg(seg_a), .dp(dp_a),
    .dig_sel(sel_a), .frame_tick(tick_a)
  );

  seg_scan_multi #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
    .BLINK_FRAMES(2), .SEG_ACTIVE_HIGH(0),
    .SEL_ACTIVE_HIGH(0)
  ) u_lo (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(ready_b),
    .upd_codes(upd_codes), .upd_dp(upd_dp),
    .upd_blink(upd_blink), .seg(seg_b), .dp(dp_b),
    .dig_sel(sel_b), .frame_tick(tick_b)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b1;

  int         m_code[4];
  bit         m_dp[4];
  bit         m_blink[4];
  logic [19:0] s_codes;
  logic [3:0]  s_dp, s_blink;
  bit         m_pend;
  int         fnum;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0:  return 7'h3F;  1:  return 7'h06;
      2:  return 7'h5B;  3:  return 7'h4F;
      4:  return 7'h66;  5:  return 7'h6D;
      6:  return 7'h7D;  7:  return 7'h07;
      8:  return 7'h7F;  9:  return 7'h6F;
      10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;
      14: return 7'h79;  15: return 7'h71;
      16: return 7'h78;  17: return 7'h0E;
      18: return 7'h40;  19: return 7'h73;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [19:0] pack4(input int c3, input int c2,
                                        input int c1, input int c0);
    logic [4:0] a, b, c, d;
    a = 5'(c3); b = 5'(c2); c = 5'(c1); d = 5'(c0);
    return {a, b, c, d};
  endfunction

  task automatic model_blank();
    for (int d = 0; d < 4; d++) begin
      m_code[d] = 31; m_dp[d] = 1'b0; m_blink[d] = 1'b0;
    end
    m_pend = 1'b0;
    fnum   = 0;
  endtask

  task automatic push_frame();
    exp_t e;
    bit   ph;
    ph = ((fnum / 2) % 2) == 1;
    for (int d = 0; d < 4; d++) begin
      e.sel = 4'(1 << d);
      if (m_blink[d] && ph) begin
        e.seg = 7'h00; e.dp = 1'b0;
      end else begin
        e.seg = glyph(m_code[d]); e.dp = m_dp[d];
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic frame_start();
    fnum++;
    if (m_pend) begin
      for (int d = 0; d < 4; d++) begin
        m_code[d]  = int'(s_codes[5*d +: 5]);
        m_dp[d]    = s_dp[d];
        m_blink[d] = s_blink[d];
      end
      m_pend = 1'b0;
      check("ready_after_commit", {ready_a, ready_b}, 2'b11);
    end
    push_frame();
  endtask

  task automatic next_frame();
    int k;
    bit low_ok;
    bit pend;
    pend   = m_pend;
    low_ok = 1'b1;
    k      = 0;
    do begin
      @(negedge clk);
      k++;
      if (!tick_a && pend && (ready_a || ready_b)) low_ok = 1'b0;
    end while (!tick_a && k < 40);
    if (pend) check("ready_low_while_pending", low_ok, 1);
    if (!tick_a) check("tick_timeout", 0, 1);
    frame_start();
  endtask

  task automatic offer(input logic [19:0] c, input logic [3:0] p,
                       input logic [3:0] b);
    upd_valid = 1'b1; upd_codes = c; upd_dp = p; upd_blink = b;
  endtask

  task automatic scramble();
    upd_valid = 1'b0;
    upd_codes = 20'hA5C3F;
    upd_dp    = 4'hF;
    upd_blink = 4'hF;
  endtask

  task automatic load_mid(input logic [19:0] c, input logic [3:0] p,
                          input logic [3:0] b, input int dly);
    repeat (dly) @(negedge clk);
    offer(c, p, b);
    @(negedge clk);
    scramble();
    s_codes = c; s_dp = p; s_blink = b; m_pend = 1'b1;
    check("ready_after_capture", {ready_a, ready_b}, 2'b00);
  endtask

  task automatic load_frame_end(input logic [19:0] c,
                                input logic [3:0] p,
                                input logic [3:0] b);
    repeat (31) @(negedge clk);
    offer(c, p, b);
    @(negedge clk);
    scramble();
    check("tick_at_fe_capture", tick_a, 1);
    frame_start();
    s_codes = c; s_dp = p; s_blink = b; m_pend = 1'b1;
    check("ready_after_fe_capture", {ready_a, ready_b}, 2'b00);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, {ready_a, ready_b}, 2'b11);
    check({tag, "_tick"}, {tick_a, tick_b}, 2'b00);
    check({tag, "_hi"}, {sel_a, seg_a, dp_a}, 12'h000);
    check({tag, "_lo"}, {sel_b, seg_b, dp_b}, 12'hFFF);
  endtask

  logic [3:0] prev_sel;
  int         run_len;
  bit         seen_show;
  bit         run_ok;
  exp_t       run_exp;
  int         cyc;
  int         last_tick;

  always @(negedge clk) begin : monitor
    logic [3:0] xs;
    logic [6:0] xg;
    logic       xd;
    bit         ok;
    if (!rst_n || !mon_en) begin
      prev_sel  = 4'h0;
      run_len   = 0;
      seen_show = 1'b0;
      run_ok    = 1'b1;
      run_exp   = '0;
      cyc       = 0;
      last_tick = -1;
    end else begin
      cyc++;
      if (sel_a != prev_sel) begin
        if (prev_sel == 4'h0) begin
          if (seen_show) begin
            check("blank_run_len", run_len, 2);
            check("blank_run_clean", run_ok, 1);
          end
        end else begin
          check("show_run_len", run_len, 6);
          check("show_run_clean", run_ok, 1);
        end
        run_len = 0;
        run_ok  = 1'b1;
        if (sel_a != 4'h0) begin
          seen_show = 1'b1;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
            run_exp = '0;
          end else begin
            run_exp = sb_q.pop_front();
            xs = ~run_exp.sel; xg = ~run_exp.seg; xd = ~run_exp.dp;
            check("dig_sel", sel_a, run_exp.sel);
            check("seg", seg_a, run_exp.seg);
            check("dp", dp_a, run_exp.dp);
            check("inv_outputs", {sel_b, seg_b, dp_b}, {xs, xg, xd});
          end
        end
      end
      run_len++;
      if (sel_a == 4'h0) begin
        ok = (seg_a == 7'h00) && !dp_a && (sel_b == 4'hF)
          && (seg_b == 7'h7F) && dp_b;
      end else begin
        xs = ~run_exp.sel; xg = ~run_exp.seg; xd = ~run_exp.dp;
        ok = (sel_a == run_exp.sel) && (seg_a == run_exp.seg)
          && (dp_a == run_exp.dp) && (sel_b == xs)
          && (seg_b == xg) && (dp_b == xd);
      end
      if (!ok) run_ok = 1'b0;
      if (tick_a) begin
        check("tick_lo_inst", tick_b, 1);
        check("tick_last_digit", sel_a, 4'b1000);
        if (last_tick >= 0) check("tick_period", cyc - last_tick, 32);
        last_tick = cyc;
      end
      prev_sel = sel_a;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    rst_n = 1'b0;
    scramble();
    model_blank();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    push_frame();
    #2 rst_n = 1'b1;

    next_frame();
    load_mid(pack4(3, 2, 1, 0), 4'b0000, 4'b0000, 10);
    next_frame();
    load_frame_end(pack4(9, 8, 7, 6), 4'b1010, 4'b0000);
    next_frame();

    load_mid(pack4(17, 16, 5, 4), 4'b0001, 4'b0100, 4);
    repeat (5) next_frame();

    load_mid(pack4(13, 12, 11, 10), 4'b1111, 4'b0000, 4);
    next_frame();
    load_mid(pack4(17, 16, 15, 14), 4'b1111, 4'b0000, 4);
    next_frame();
    load_mid(pack4(0, 25, 19, 18), 4'b1111, 4'b0000, 4);
    next_frame();

    load_mid(pack4(1, 1, 1, 1), 4'b1111, 4'b0000, 4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    reset_checks("mid_reset");
    sb_q.delete();
    model_blank();
    push_frame();
    #2 rst_n = 1'b1;
    next_frame();
    next_frame();

    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drain", sb_q.size(), 0);
    mon_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
